// File: rtl/jet_feature_loader.sv
// jet_feature_loader: collects a serial stream of jet features into a ping-pong
// buffer and hands each complete frame to the inference core with a start pulse.
module jet_feature_loader #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned INPUT_SIZE = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic                    input_ready,
  output logic signed [WIDTH-1:0] input_data [INPUT_SIZE],
  input  logic                    core_done,
  output logic                    frame_err,
  output logic [CNT_W-1:0]        frame_count
);

  localparam int unsigned IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_BUSY
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              full_q, full_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    fill_bank_q, fill_bank_d;
  logic                    pres_bank_q, pres_bank_d;
  logic                    done_prev_q, done_prev_d;
  logic                    s_ready_q, s_ready_d;
  logic                    input_ready_q, input_ready_d;
  logic                    frame_err_q, frame_err_d;
  logic [CNT_W-1:0]        frame_count_q, frame_count_d;
  logic signed [WIDTH-1:0] data_q [INPUT_SIZE];
  logic signed [WIDTH-1:0] data_d [INPUT_SIZE];
  logic signed [WIDTH-1:0] bank_q [2][INPUT_SIZE];
  logic signed [WIDTH-1:0] bank_d [2][INPUT_SIZE];

  logic accept;
  logic done_rise;

  assign accept    = s_valid && s_ready_q;
  assign done_rise = core_done && !done_prev_q;

  // Next-state logic: fill side writes the open bank, presenter walks IDLE/START/BUSY.
  always_comb begin
    state_d       = state_q;
    full_d        = full_q;
    idx_d         = idx_q;
    fill_bank_d   = fill_bank_q;
    pres_bank_d   = pres_bank_q;
    done_prev_d   = core_done;
    input_ready_d = 1'b0;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;
    data_d        = data_q;
    bank_d        = bank_q;

    unique case (state_q)
      ST_IDLE: begin
        if (full_q[pres_bank_q]) begin
          state_d       = ST_START;
          input_ready_d = 1'b1;
          data_d        = bank_q[pres_bank_q];
        end
      end
      ST_START: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (done_rise) begin
          full_d[pres_bank_q] = 1'b0;
          pres_bank_d         = ~pres_bank_q;
          frame_count_d       = frame_count_q + CNT_W'(1);
          state_d             = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A bad frame only ever touches a bank that is not full, so the presented copy is safe.
    if (accept) begin
      bank_d[fill_bank_q][idx_q] = s_data;
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
        if (s_last) begin
          full_d[fill_bank_q] = 1'b1;
          fill_bank_d         = ~fill_bank_q;
        end else begin
          frame_err_d = 1'b1;
        end
      end else if (s_last) begin
        idx_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    s_ready_d = !full_d[fill_bank_d];
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      full_q        <= '0;
      idx_q         <= '0;
      fill_bank_q   <= 1'b0;
      pres_bank_q   <= 1'b0;
      done_prev_q   <= 1'b0;
      s_ready_q     <= 1'b0;
      input_ready_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
      for (int i = 0; i < INPUT_SIZE; i++) data_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      idx_q         <= idx_d;
      fill_bank_q   <= fill_bank_d;
      pres_bank_q   <= pres_bank_d;
      done_prev_q   <= done_prev_d;
      s_ready_q     <= s_ready_d;
      input_ready_q <= input_ready_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
      data_q        <= data_d;
    end
  end

  // Ping-pong storage; contents are only meaningful once the bank's full flag is set.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  assign s_ready     = s_ready_q;
  assign input_ready = input_ready_q;
  assign input_data  = data_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

endmodule
